// File: rtl/rect_fill_renderer.sv
// rtl/rect_fill_renderer.sv - per-frame clear plus filled-rectangle rasteriser driving the framebuffer write port
//
// rect_fill_cmd_fifo: command queue between the sprite logic and the renderer.
//   clk, rst      clock / asynchronous active-high reset
//   push, wdata   write side (ignored while full)
//   pop, rdata    read side, rdata shows the head entry (ignored while empty)
//   full, empty   occupancy flags
//
// rect_fill_renderer: clears the back buffer, then draws queued rectangles in painter's order.
//   SEL_CLK, RESET               clock / asynchronous active-high reset
//   FRAME_START                  one-cycle pulse starting a frame
//   cmd_valid, cmd_ready         command handshake (cmd_ready = queue not full)
//   cmd_x0/y0/w/h/color/last     rectangle command, cmd_last closes the frame
//   RENDER_EN/RENDER_INDEX/FB_IN registered framebuffer write port
//   busy, frame_done, overrun    status

module rect_fill_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module rect_fill_renderer #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int H_RES       = 320,
  parameter int V_RES       = 200,
  parameter int XW          = 9,
  parameter int YW          = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int CLEAR_COLOR = 0
) (
  input  logic                  SEL_CLK,
  input  logic                  RESET,
  input  logic                  FRAME_START,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [XW-1:0]         cmd_w,
  input  logic [YW-1:0]         cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  input  logic                  cmd_last,
  output logic                  RENDER_EN,
  output logic [ADDR_WIDTH-1:0] RENDER_INDEX,
  output logic [DATA_WIDTH-1:0] FB_IN,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);
  localparam int CW = 2*XW + 2*YW + DATA_WIDTH + 1;
  localparam logic [XW:0]           H_LIM    = (XW+1)'(H_RES);
  localparam logic [YW:0]           V_LIM    = (YW+1)'(V_RES);
  localparam logic [XW-1:0]         X_LAST   = XW'(H_RES-1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(V_RES-1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_RES);
  localparam logic [DATA_WIDTH-1:0] CLR_COL  = DATA_WIDTH'(CLEAR_COLOR);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAW, DONE} state_t;
  state_t state, state_n;

  // Command queue
  logic                  fifo_full, fifo_empty, pop;
  logic [CW-1:0]         f_data;
  logic [XW-1:0]         f_x0, f_w;
  logic [YW-1:0]         f_y0, f_h;
  logic [DATA_WIDTH-1:0] f_color;
  logic                  f_last;

  assign cmd_ready = !fifo_full;
  assign {f_x0, f_y0, f_w, f_h, f_color, f_last} = f_data;

  rect_fill_cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (SEL_CLK),
    .rst   (RESET),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_last}),
    .rdata (f_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clipping of the head command; one extra bit so x0+w cannot wrap.
  logic [XW:0] sum_x, clip_xe;
  logic [YW:0] sum_y, clip_ye;
  logic        rect_empty;

  assign sum_x      = {1'b0, f_x0} + {1'b0, f_w};
  assign sum_y      = {1'b0, f_y0} + {1'b0, f_h};
  assign clip_xe    = (sum_x > H_LIM) ? H_LIM : sum_x;
  assign clip_ye    = (sum_y > V_LIM) ? V_LIM : sum_y;
  assign rect_empty = ({1'b0, f_x0} >= clip_xe) || ({1'b0, f_y0} >= clip_ye);

  // Raster walker state
  logic [XW-1:0]         x, x_n, xs, xs_n;
  logic [XW:0]           xe, xe_n;
  logic [YW-1:0]         y, y_n;
  logic [YW:0]           ye, ye_n;
  logic [ADDR_WIDTH-1:0] row_base, row_base_n;
  logic [DATA_WIDTH-1:0] color, color_n, wr_col;
  logic                  last_cmd, last_cmd_n, wr;

  logic rect_row_end, rect_bottom;
  assign rect_row_end = (({1'b0, x} + (XW+1)'(1)) == xe);
  assign rect_bottom  = (({1'b0, y} + (YW+1)'(1)) == ye);

  always_ff @(posedge SEL_CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    wr         = 1'b0;
    wr_col     = color;
    x_n        = x;
    y_n        = y;
    xs_n       = xs;
    xe_n       = xe;
    ye_n       = ye;
    row_base_n = row_base;
    color_n    = color;
    last_cmd_n = last_cmd;
    case (state)
      IDLE: begin
        if (FRAME_START) begin
          state_n    = CLEAR;
          x_n        = '0;
          y_n        = '0;
          row_base_n = '0;
        end
      end
      CLEAR: begin
        wr     = 1'b1;
        wr_col = CLR_COL;
        if (x == X_LAST) begin
          x_n        = '0;
          y_n        = y + YW'(1);
          row_base_n = row_base + ROW_STEP;
          if (y == Y_LAST) state_n = FETCH;
        end else begin
          x_n = x + XW'(1);
        end
      end
      FETCH: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          xs_n       = f_x0;
          xe_n       = clip_xe;
          ye_n       = clip_ye;
          x_n        = f_x0;
          y_n        = f_y0;
          // Once per command, outside the per-pixel path.
          row_base_n = ADDR_WIDTH'(f_y0) * ROW_STEP;
          color_n    = f_color;
          last_cmd_n = f_last;
          if (rect_empty) state_n = f_last ? DONE : FETCH;
          else            state_n = DRAW;
        end
      end
      DRAW: begin
        wr = 1'b1;
        if (rect_row_end) begin
          x_n = xs;
          if (rect_bottom) begin
            state_n = last_cmd ? DONE : FETCH;
          end else begin
            y_n        = y + YW'(1);
            row_base_n = row_base + ROW_STEP;
          end
        end else begin
          x_n = x + XW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge SEL_CLK or posedge RESET) begin
    if (RESET) begin
      x        <= '0;
      y        <= '0;
      xs       <= '0;
      xe       <= '0;
      ye       <= '0;
      row_base <= '0;
      color    <= '0;
      last_cmd <= 1'b0;
    end else begin
      x        <= x_n;
      y        <= y_n;
      xs       <= xs_n;
      xe       <= xe_n;
      ye       <= ye_n;
      row_base <= row_base_n;
      color    <= color_n;
      last_cmd <= last_cmd_n;
    end
  end

  // Write port is registered; index and data hold when no write is issued.
  always_ff @(posedge SEL_CLK or posedge RESET) begin
    if (RESET) begin
      RENDER_EN    <= 1'b0;
      RENDER_INDEX <= '0;
      FB_IN        <= '0;
      overrun      <= 1'b0;
    end else begin
      RENDER_EN <= wr;
      if (wr) begin
        RENDER_INDEX <= row_base + ADDR_WIDTH'(x);
        FB_IN        <= wr_col;
      end
      overrun <= FRAME_START && (state != IDLE);
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
endmodule

// File: tb/tb_rect_fill_renderer.sv
// tb/tb_rect_fill_renderer.sv - self-checking bench for rect_fill_renderer
module tb_rect_fill_renderer;
  localparam int DW = 4, AW = 16, H = 8, V = 4, XW = 4, YW = 3, FD = 4;

  logic          SEL_CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FRAME_START = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_last = 1'b0;
  logic [XW-1:0] cmd_x0 = '0, cmd_w = '0;
  logic [YW-1:0] cmd_y0 = '0, cmd_h = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          cmd_ready, RENDER_EN, busy, frame_done, overrun;
  logic [AW-1:0] RENDER_INDEX;
  logic [DW-1:0] FB_IN;

  rect_fill_renderer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_RES(H), .V_RES(V),
    .XW(XW), .YW(YW), .FIFO_DEPTH(FD), .CLEAR_COLOR(0)
  ) dut (
    .SEL_CLK(SEL_CLK), .RESET(RESET), .FRAME_START(FRAME_START),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_last(cmd_last),
    .RENDER_EN(RENDER_EN), .RENDER_INDEX(RENDER_INDEX), .FB_IN(FB_IN),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 SEL_CLK = ~SEL_CLK;

  int n_checks = 0, n_fail = 0;
  int wq_idx[$], wq_col[$];
  int exp_idx[$], exp_col[$];
  int lat, first_k, ovr_cnt, rdy_first;

  typedef struct {
    int x0, y0, w, h, c;
    int npix, first, last;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cmd(input int x0, input int y0, input int w, input int h,
                          input int c, input int last);
    int t;
    @(negedge SEL_CLK);
    cmd_x0 = XW'(x0); cmd_y0 = YW'(y0); cmd_w = XW'(w); cmd_h = YW'(h);
    cmd_color = DW'(c); cmd_last = (last != 0); cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge SEL_CLK);
      t++;
    end
    check("push_ready", int'(cmd_ready), 1);
    @(negedge SEL_CLK);
    cmd_valid = 1'b0;
  endtask

  // Pulse FRAME_START and record every write until frame_done; k counts edges after the start edge.
  task automatic run_frame(input int restart_at);
    int k;
    wq_idx.delete(); wq_col.delete();
    lat = -1; first_k = -1; ovr_cnt = 0; rdy_first = -1;
    @(negedge SEL_CLK);
    FRAME_START = 1'b1;
    @(negedge SEL_CLK);
    FRAME_START = 1'b0;
    k = 0;
    forever begin
      if (RENDER_EN) begin
        if (first_k < 0) begin
          first_k = k;
          rdy_first = int'(cmd_ready);
        end
        wq_idx.push_back(int'(RENDER_INDEX));
        wq_col.push_back(int'(FB_IN));
      end
      if (overrun) ovr_cnt++;
      if (frame_done) begin
        lat = k;
        break;
      end
      if (k >= 2000) begin
        check("frame_timeout", 0, 1);
        break;
      end
      FRAME_START = (k == restart_at);
      @(negedge SEL_CLK);
      k++;
    end
    FRAME_START = 1'b0;
    @(negedge SEL_CLK);
    check("done_single_pulse", int'(frame_done), 0);
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic check_common(input string tag, input int ncmd, input int npix, input int exp_ovr);
    int ok;
    ok = 1;
    check({tag, "_first_write_cycle"}, first_k, 1);
    if (wq_idx.size() < H*V) ok = 0;
    else for (int i = 0; i < H*V; i++) if (wq_idx[i] != i || wq_col[i] != 0) ok = 0;
    check({tag, "_clear_seq"}, ok, 1);
    check({tag, "_draw_count"}, wq_idx.size() - H*V, npix);
    check({tag, "_latency"}, lat, H*V + ncmd + npix);
    check({tag, "_overrun"}, ovr_cnt, exp_ovr);
  endtask

  // Reference: painter's order, rows top to bottom, clipped to the screen.
  task automatic rand_frame(input int f);
    int nc, x0, y0, w, h, col, xend, yend, ok;
    nc = $urandom_range(1, FD);
    exp_idx.delete(); exp_col.delete();
    for (int c = 0; c < nc; c++) begin
      x0 = $urandom_range(0, 10); y0 = $urandom_range(0, 5);
      w = $urandom_range(0, 15); h = $urandom_range(0, 7);
      col = $urandom_range(0, 15);
      push_cmd(x0, y0, w, h, col, (c == nc-1) ? 1 : 0);
      xend = (x0 + w < H) ? x0 + w : H;
      yend = (y0 + h < V) ? y0 + h : V;
      for (int yy = y0; yy < yend; yy++)
        for (int xx = x0; xx < xend; xx++) begin
          exp_idx.push_back(yy*H + xx);
          exp_col.push_back(col);
        end
    end
    run_frame(-1);
    check_common($sformatf("rand%0d", f), nc, exp_idx.size(), 0);
    ok = (wq_idx.size() == H*V + exp_idx.size()) ? 1 : 0;
    if (ok == 1)
      for (int i = 0; i < exp_idx.size(); i++)
        if (wq_idx[H*V+i] != exp_idx[i] || wq_col[H*V+i] != exp_col[i]) ok = 0;
    check($sformatf("rand%0d_draw_seq", f), ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ok, cnt_w, cnt_d;
    vecs[0] = '{2, 1, 3, 2, 5,   6, 10, 20};
    vecs[1] = '{6, 3, 5, 4, 9,   2, 30, 31};
    vecs[2] = '{0, 0, 0, 1, 3,   0,  0,  0};
    vecs[3] = '{0, 0, 8, 4, 7,  32,  0, 31};
    vecs[4] = '{7, 0, 1, 1, 2,   1,  7,  7};
    vecs[5] = '{9, 0, 3, 1, 4,   0,  0,  0};
    vecs[6] = '{0, 2, 2, 7, 11,  4, 16, 25};
    vecs[7] = '{5, 0, 15, 7, 13, 12, 5, 31};
    vecs[8] = '{1, 1, 3, 0, 6,   0,  0,  0};

    // Reset state
    repeat (3) @(negedge SEL_CLK);
    check("rst_en", int'(RENDER_EN), 0);
    check("rst_ready", int'(cmd_ready), 1);
    RESET = 1'b0;
    repeat (2) @(negedge SEL_CLK);
    check("idle_en", int'(RENDER_EN), 0);
    check("idle_index", int'(RENDER_INDEX), 0);
    check("idle_fb_in", int'(FB_IN), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(frame_done), 0);
    check("idle_overrun", int'(overrun), 0);
    check("idle_ready", int'(cmd_ready), 1);

    // Table-driven single-rectangle frames
    for (int i = 0; i < 9; i++) begin
      push_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].c, 1);
      run_frame(-1);
      check_common($sformatf("vec%0d", i), 1, vecs[i].npix, 0);
      if (vecs[i].npix > 0 && wq_idx.size() > H*V) begin
        check($sformatf("vec%0d_first_idx", i), wq_idx[H*V], vecs[i].first);
        check($sformatf("vec%0d_last_idx", i), wq_idx[wq_idx.size()-1], vecs[i].last);
        ok = 1;
        for (int j = H*V; j < wq_col.size(); j++) if (wq_col[j] != vecs[i].c) ok = 0;
        check($sformatf("vec%0d_colour", i), ok, 1);
      end
    end

    // FRAME_START during the clear
    push_cmd(0, 0, 0, 0, 0, 1);
    run_frame(10);
    check_common("overrun", 1, 0, 1);

    // FIFO full: fifth command refused
    for (int i = 0; i < FD; i++) push_cmd(i, 0, 1, 1, i+1, (i == FD-1) ? 1 : 0);
    @(negedge SEL_CLK);
    check("fifo_full_ready", int'(cmd_ready), 0);
    cmd_x0 = 4; cmd_y0 = 0; cmd_w = 1; cmd_h = 1; cmd_color = 15; cmd_last = 1'b1;
    cmd_valid = 1'b1;
    repeat (3) @(negedge SEL_CLK);
    cmd_valid = 1'b0;
    check("fifo_full_still", int'(cmd_ready), 0);
    run_frame(-1);
    check_common("fifo", FD, FD, 0);
    check("fifo_ready_in_clear", rdy_first, 0);
    check("fifo_ready_after", int'(cmd_ready), 1);
    ok = (wq_idx.size() == H*V + FD) ? 1 : 0;
    if (ok == 1)
      for (int i = 0; i < FD; i++) if (wq_idx[H*V+i] != i || wq_col[H*V+i] != i+1) ok = 0;
    check("fifo_draw_seq", ok, 1);
    push_cmd(0, 0, 0, 0, 0, 1);
    run_frame(-1);
    check_common("fifo_next", 1, 0, 0);

    // Reset in the middle of a draw
    push_cmd(0, 0, 8, 4, 6, 0);
    push_cmd(7, 3, 1, 1, 12, 1);
    @(negedge SEL_CLK);
    FRAME_START = 1'b1;
    @(negedge SEL_CLK);
    FRAME_START = 1'b0;
    repeat (40) @(negedge SEL_CLK);
    check("pre_reset_en", int'(RENDER_EN), 1);
    check("pre_reset_col", int'(FB_IN), 6);
    RESET = 1'b1;
    #1;
    check("reset_en_drop", int'(RENDER_EN), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(cmd_ready), 1);
    @(negedge SEL_CLK);
    RESET = 1'b0;
    cnt_w = 0; cnt_d = 0;
    repeat (50) begin
      @(negedge SEL_CLK);
      if (RENDER_EN) cnt_w++;
      if (frame_done) cnt_d++;
    end
    check("post_reset_writes", cnt_w, 0);
    check("post_reset_done", cnt_d, 0);
    push_cmd(0, 0, 0, 0, 0, 1);
    run_frame(-1);
    check_common("after_reset", 1, 0, 0);

    // Randomized frames against the reference
    for (int f = 0; f < 20; f++) rand_frame(f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rect_fill_renderer.md
Name: rect_fill_renderer

Overview:
- Upstream render stage for the double-buffered framebuffer.
- Once per frame, it clears the back buffer to a fixed colour, then rasterises queued axis-aligned filled rectangles into it.
- It drives the framebuffer write side: RENDER_EN, RENDER_INDEX, FB_IN.
- Rectangle commands come from the game/sprite logic through a small command FIFO with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 4, pixel colour width; matches the framebuffer.
- ADDR_WIDTH, 16, framebuffer address width.
- H_RES, 320, pixels per line.
- V_RES, 200, lines per frame. H_RES*V_RES must be <= 2**ADDR_WIDTH.
- XW, 9, x-coordinate/width bits, >= clog2(H_RES+1).
- YW, 8, y-coordinate/height bits, >= clog2(V_RES+1).
- FIFO_DEPTH, 8, command FIFO entries; power of two.
- CLEAR_COLOR, 0, colour written during the clear phase.

Ports:
- SEL_CLK, in, 1, block clock; also the write-side clock of the framebuffer.
- RESET, in, 1, asynchronous, active-high.
- FRAME_START, in, 1, one-cycle pulse that starts rendering a frame.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, FIFO can accept; equals !full.
- cmd_x0, in, XW, rectangle left x.
- cmd_y0, in, YW, rectangle top y.
- cmd_w, in, XW, width in pixels.
- cmd_h, in, YW, height in pixels.
- cmd_color, in, DATA_WIDTH, fill colour.
- cmd_last, in, 1, last command of the frame.
- RENDER_EN, out, 1, framebuffer write strobe.
- RENDER_INDEX, out, ADDR_WIDTH, write address = y*H_RES + x.
- FB_IN, out, DATA_WIDTH, write data.
- busy, out, 1, high whenever state != IDLE.
- frame_done, out, 1, one-cycle pulse when the frame is complete.
- overrun, out, 1, one-cycle pulse when FRAME_START arrives while busy.

Behaviour:
Reset:
- Asynchronous reset on RESET; all state on SEL_CLK rising edge.
- Reset values: state IDLE, FIFO empty, x/y counters 0.
- All outputs 0, except cmd_ready = 1.
- Reset mid-frame aborts the frame immediately: no further writes and no frame_done.

Command FIFO:
- Push when cmd_valid & cmd_ready.
- Pop only in the FETCH state.
- Simultaneous push and pop when full: the push is refused, because cmd_ready is already low.
- The FIFO accepts pushes in every state, so the next frame's commands can be queued early.

State machine:
- IDLE:
  - FRAME_START -> CLEAR; x and y counters are zeroed.
- CLEAR:
  - Writes indices 0 .. H_RES*V_RES-1 in order, one per cycle, with colour CLEAR_COLOR.
  - After the last index -> FETCH.
- FETCH:
  - If the FIFO is empty, stay in FETCH; no write is issued.
  - Otherwise, pop one command and latch clipped bounds:
    - xs = x0
    - ys = y0
    - xe = min(x0+w, H_RES)
    - ye = min(y0+h, V_RES)
    - Sums are computed at XW+1 / YW+1 bits, so there is no wrap.
  - If xs >= xe or ys >= ye, the rectangle is empty: no write.
    - last = 1 -> DONE.
    - Otherwise -> FETCH again.
  - Otherwise -> DRAW.
- DRAW:
  - Raster order: x runs xs..xe-1 within a row, then y increments.
  - One write per cycle; RENDER_INDEX = row_base + x.
  - row_base is maintained incrementally: it starts at ys*H_RES and adds H_RES per row. No multiplier is allowed in the per-pixel path.
  - After pixel (xe-1, ye-1): last = 1 -> DONE; otherwise -> FETCH.
- DONE:
  - frame_done = 1 for exactly one cycle, then IDLE.

Output timing and rules:
- RENDER_EN, RENDER_INDEX and FB_IN are registered.
- A write decided in cycle N is visible after edge N+1.
- FRAME_START sampled at edge N -> the first write (index 0) is visible after edge N+1.
- Clear cost: exactly H_RES*V_RES consecutive RENDER_EN cycles.
- Draw cost: one FETCH cycle per command, plus one cycle per clipped pixel.
- Later rectangles overwrite earlier ones (painter's order).
- When RENDER_EN = 0, RENDER_INDEX and FB_IN hold their last values.
- FRAME_START while busy: pulse overrun, ignore the start, continue the current frame. FRAME_START in IDLE never produces overrun.
- A command without cmd_last leaves the block waiting in FETCH indefinitely. This is legal; busy stays high.

Test Plan (bench uses H_RES=8, V_RES=4, XW=4, YW=3, FIFO_DEPTH=4, CLEAR_COLOR=0):
- Reset then idle -> all outputs 0, cmd_ready=1, busy=0.
- FRAME_START with one command {x0=2, y0=1, w=3, h=2, color=5, last=1} queued:
  - 32 writes of colour 0 at indices 0..31.
  - Then writes of colour 5 at indices 10, 11, 12, 18, 19, 20.
  - Then frame_done pulses once and busy drops.
- Clipping: {x0=6, y0=3, w=5, h=4, color=9, last=1} -> after the clear, only indices 30 and 31 are written with colour 9.
- Empty end marker {w=0, last=1}: frame_done follows the clear with zero draw writes. FRAME_START pulsed mid-clear -> overrun pulses once and the clear still reaches index 31.
- FIFO full:
  - Push 4 commands while in IDLE -> cmd_ready=0.
  - A 5th cmd_valid is not accepted.
  - After FRAME_START and the first FETCH pop, cmd_ready returns to 1.
- RESET asserted mid-DRAW:
  - RENDER_EN falls to 0 immediately and the FIFO is empty.
  - No frame_done; the next FRAME_START restarts the clear from index 0.
